sprite_overlay_engine: RTL and testbench
========================================

Name: sprite_overlay_engine

Overview:
Parametrised sprite compositor and wall-collision detector for the VGA pixel path. It sits between the background palette lookup (24-bit BGR per pixel) and the DAC outputs. It overlays NUM_SPRITES solid-colour rectangular sprites with fixed priority. Per frame, it reports, for each sprite, whether the background pixel immediately above, below, left or right of that sprite matches the wall colour. Sprite state is double-buffered at frame boundaries, so positions never tear mid-frame.

Parameters:
NUM_SPRITES, 4, number of sprites (1..8); sprite 0 has highest priority
SPRITE_W, 24, sprite bounding width in pixels
SPRITE_H, 24, sprite bounding height in pixels
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame

Ports:
iVGA_CLK  in  1  pixel clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
iBLANK_n  in  1  active-video qualifier, one pixel per cycle while 1
iVS  in  1  vertical sync, active-low
iBG_BGR  in  24  background pixel, aligned with iBLANK_n
iWALL_COLOR  in  24  background colour treated as wall
iSPR_EN  in  NUM_SPRITES  per-sprite enable
iSPR_X  in  10*NUM_SPRITES  packed x positions, sprite i at [10i+9:10i]
iSPR_Y  in  9*NUM_SPRITES  packed y positions
iSPR_COLOR  in  24*NUM_SPRITES  packed BGR colours
oBGR  out  24  composited pixel
oBLANK_n  out  1  iBLANK_n delayed 2 cycles
oVS  out  1  iVS delayed 2 cycles
oCOLL_UP, oCOLL_DOWN, oCOLL_LEFT, oCOLL_RIGHT  out  NUM_SPRITES each  per-sprite collision flags for the last complete frame
oCOLL_VALID  out  1  one-cycle pulse when collision flags update

Behaviour:
- Reset clears all state. Raster x/y, shadows, accumulators and outputs are all 0, and frame_seen=0.
- Frame boundary is the iVS falling edge, detected against a registered iVS.
- Raster counters:
  - x is 10 bits and y is 9 bits.
  - Both clear on the frame boundary.
  - While iBLANK_n=1, x increments. At x=H_ACTIVE-1, x wraps to 0 and y increments.
  - y holds at V_ACTIVE-1 and does not wrap.
- Shadow registers:
  - iSPR_EN, iSPR_X, iSPR_Y and iSPR_COLOR are sampled only on the frame-boundary cycle.
  - All hit and collision logic uses the shadows. Input changes mid-frame have no effect until the next frame.
- Hit test for sprite i requires all of the following: en_i, X_i < x < X_i+SPRITE_W, and Y_i < y < Y_i+SPRITE_H.
  - Sums are computed 1 bit wider than the operands, with no wrap. This means a sprite near the right or bottom edge is clipped, not wrapped.
- Pipeline, 2-cycle latency from the iBG_BGR/iBLANK_n input to the outputs:
  - Stage 1 registers the hit vector, background, blank and VS.
  - Stage 2 selects the colour of the lowest-index hit sprite, else the background.
  - oBGR=0 whenever the stage-2 blank bit is 0.
- Collision probes for sprite i, evaluated only while iBLANK_n=1 and en_i=1, comparing iBG_BGR with iWALL_COLOR (exact 24-bit equality):
  - UP: y==Y_i and X_i < x < X_i+SPRITE_W
  - DOWN: y==Y_i+SPRITE_H and the same x span
  - LEFT: x==X_i and Y_i < y < Y_i+SPRITE_H
  - RIGHT: x==X_i+SPRITE_W and the same y span
  - Any match sets the sticky accumulator bit for that sprite and direction.
  - Probes see the background only; sprite-to-sprite overlap never counts as a collision.
- On a frame boundary:
  - If frame_seen=1, the accumulators are copied to the oCOLL_* outputs and oCOLL_VALID=1 for exactly that cycle.
  - Accumulators clear and frame_seen is set to 1.
  - When the shadow load and the accumulator transfer happen in the same cycle, the transferred flags belong to the old frame's positions.
- The first frame boundary after reset does not pulse oCOLL_VALID, because that frame was partial.
- oCOLL_* hold their value between pulses.
- Reset mid-frame clears everything immediately; the next valid pulse comes two frame boundaries later.

Test Plan:
- Reset, then drive 2 frames with no sprites enabled and background 24'h000000 -> oBGR=0 throughout. oCOLL_VALID pulses once, at the second boundary, and all flags are 0.
- Sprite 0 at (100,50) in FF0000 overlapping sprite 1 at (110,50) in 00FF00 -> pixel (115,60) shows FF0000 two cycles after input. Pixel (130,60) shows 00FF00. Pixel (101,51) is sprite 0 and pixel (100,51) is background.
- Change iSPR_X[9:0] from 100 to 200 mid-frame -> the rest of the frame still renders at x=100, and the next frame renders at x=200.
- Wall colour FF5757 on row y=50 only, with sprite 0 at (100,50) -> after the following boundary, oCOLL_UP[0]=1 and DOWN/LEFT/RIGHT[0]=0. Moving the wall to column x=124 instead gives oCOLL_RIGHT[0]=1.
- Sprite at X=630 -> pixels at x=631..639 show the sprite, and x=0..13 on the same lines show background (no wrap).
- Assert reset on line 200 of a frame that has wall contact -> outputs clear. No oCOLL_VALID at the next boundary; the one after that reports a full frame.

Source files
------------

// File: rtl/sprite_overlay_engine.sv
// sprite_overlay_engine
//   Composites NUM_SPRITES solid-colour rectangles over the background pixel
//   stream with fixed priority, where sprite 0 has the highest priority. Once
//   per frame it also reports, for each sprite, whether the wall colour touches
//   the background just above, below, left of or right of that sprite.
//   Sprite state is captured at the iVS falling edge, so mid-frame updates on
//   the iSPR_* inputs never tear the picture.
// Ports
//   iVGA_CLK, reset      pixel clock, async active-high reset
//   iBLANK_n, iVS        active-video qualifier, vertical sync (active low)
//   iBG_BGR, iWALL_COLOR background pixel, colour treated as wall
//   iSPR_EN/X/Y/COLOR    packed per-sprite enable, position, colour
//   oBGR, oBLANK_n, oVS  composited pixel stream (2-cycle latency)
//   oCOLL_*              per-sprite collision flags for the last full frame
//   oCOLL_VALID          one-cycle pulse when oCOLL_* update
module sprite_overlay_engine #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 24,
  parameter int SPRITE_H    = 24,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480
) (
  input  logic                      iVGA_CLK,
  input  logic                      reset,
  input  logic                      iBLANK_n,
  input  logic                      iVS,
  input  logic [23:0]               iBG_BGR,
  input  logic [23:0]               iWALL_COLOR,
  input  logic [NUM_SPRITES-1:0]    iSPR_EN,
  input  logic [10*NUM_SPRITES-1:0] iSPR_X,
  input  logic [9*NUM_SPRITES-1:0]  iSPR_Y,
  input  logic [24*NUM_SPRITES-1:0] iSPR_COLOR,
  output logic [23:0]               oBGR,
  output logic                      oBLANK_n,
  output logic                      oVS,
  output logic [NUM_SPRITES-1:0]    oCOLL_UP,
  output logic [NUM_SPRITES-1:0]    oCOLL_DOWN,
  output logic [NUM_SPRITES-1:0]    oCOLL_LEFT,
  output logic [NUM_SPRITES-1:0]    oCOLL_RIGHT,
  output logic                      oCOLL_VALID
);

  logic                      vs_q;
  logic                      frame_start;
  logic [9:0]                x;
  logic [8:0]                y;
  logic [10:0]               x_ext;
  logic [9:0]                y_ext;
  logic [NUM_SPRITES-1:0]    sh_en;
  logic [10*NUM_SPRITES-1:0] sh_x;
  logic [9*NUM_SPRITES-1:0]  sh_y;
  logic [24*NUM_SPRITES-1:0] sh_color;
  logic [NUM_SPRITES-1:0]    hit, hit_q;
  logic [NUM_SPRITES-1:0]    pr_up, pr_down, pr_left, pr_right;
  logic [NUM_SPRITES-1:0]    acc_up, acc_down, acc_left, acc_right;
  logic                      frame_seen;
  logic [23:0]               bg_q;
  logic                      blank_q;
  logic [23:0]               sel_color;
  logic                      wall_hit;

  // vs_q doubles as the stage-1 copy of iVS and the edge-detect reference
  assign frame_start = vs_q & ~iVS;
  assign x_ext       = {1'b0, x};
  assign y_ext       = {1'b0, y};
  assign wall_hit    = (iBG_BGR == iWALL_COLOR);

  // Bounds are one bit wider than the position so edge sprites clip instead of wrapping
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
    logic [10:0] xs, xe;
    logic [9:0]  ys, ye;
    logic        in_x, in_y, probe_ok;
    assign xs       = {1'b0, sh_x[10*g +: 10]};
    assign xe       = xs + 11'(SPRITE_W);
    assign ys       = {1'b0, sh_y[9*g +: 9]};
    assign ye       = ys + 10'(SPRITE_H);
    assign in_x     = (x_ext > xs) && (x_ext < xe);
    assign in_y     = (y_ext > ys) && (y_ext < ye);
    assign hit[g]   = sh_en[g] & in_x & in_y;
    assign probe_ok = iBLANK_n & sh_en[g] & wall_hit;
    assign pr_up[g]    = probe_ok & (y_ext == ys) & in_x;
    assign pr_down[g]  = probe_ok & (y_ext == ye) & in_x;
    assign pr_left[g]  = probe_ok & (x_ext == xs) & in_y;
    assign pr_right[g] = probe_ok & (x_ext == xe) & in_y;
  end

  // Descending scan so the lowest-index hit wins
  always_comb begin
    sel_color = bg_q;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_q[i]) sel_color = sh_color[24*i +: 24];
    end
  end

  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (frame_start) begin
      x <= '0;
      y <= '0;
    end else if (iBLANK_n) begin
      if (x == 10'(H_ACTIVE - 1)) begin
        x <= '0;
        if (y != 9'(V_ACTIVE - 1)) y <= y + 9'd1;
      end else begin
        x <= x + 10'd1;
      end
    end
  end

  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      sh_en    <= '0;
      sh_x     <= '0;
      sh_y     <= '0;
      sh_color <= '0;
    end else if (frame_start) begin
      sh_en    <= iSPR_EN;
      sh_x     <= iSPR_X;
      sh_y     <= iSPR_Y;
      sh_color <= iSPR_COLOR;
    end
  end

  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      vs_q     <= 1'b0;
      hit_q    <= '0;
      bg_q     <= '0;
      blank_q  <= 1'b0;
      oBGR     <= '0;
      oBLANK_n <= 1'b0;
      oVS      <= 1'b0;
    end else begin
      vs_q     <= iVS;
      hit_q    <= hit;
      bg_q     <= iBG_BGR;
      blank_q  <= iBLANK_n;
      oBGR     <= blank_q ? sel_color : 24'h000000;
      oBLANK_n <= blank_q;
      oVS      <= vs_q;
    end
  end

  // Transfer uses accumulators built with the outgoing frame's shadows
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      acc_up      <= '0;
      acc_down    <= '0;
      acc_left    <= '0;
      acc_right   <= '0;
      oCOLL_UP    <= '0;
      oCOLL_DOWN  <= '0;
      oCOLL_LEFT  <= '0;
      oCOLL_RIGHT <= '0;
      oCOLL_VALID <= 1'b0;
      frame_seen  <= 1'b0;
    end else if (frame_start) begin
      if (frame_seen) begin
        oCOLL_UP    <= acc_up;
        oCOLL_DOWN  <= acc_down;
        oCOLL_LEFT  <= acc_left;
        oCOLL_RIGHT <= acc_right;
      end
      oCOLL_VALID <= frame_seen;
      acc_up      <= '0;
      acc_down    <= '0;
      acc_left    <= '0;
      acc_right   <= '0;
      frame_seen  <= 1'b1;
    end else begin
      oCOLL_VALID <= 1'b0;
      acc_up      <= acc_up    | pr_up;
      acc_down    <= acc_down  | pr_down;
      acc_left    <= acc_left  | pr_left;
      acc_right   <= acc_right | pr_right;
    end
  end

endmodule

// File: tb/tb_sprite_overlay_engine.sv
module tb_sprite_overlay_engine;

  localparam int N = 4;
  localparam logic [23:0] WALL = 24'hFF5757;

  logic          clk = 1'b0;
  logic          reset;
  logic          blank_n;
  logic          vs;
  logic [23:0]   bg;
  logic [23:0]   wall_color;
  logic [N-1:0]  spr_en;
  logic [10*N-1:0] spr_x;
  logic [9*N-1:0]  spr_y;
  logic [24*N-1:0] spr_color;
  logic [23:0]   bgr;
  logic          blank_out;
  logic          vs_out;
  logic [N-1:0]  coll_up, coll_down, coll_left, coll_right;
  logic          coll_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int bx = 0;
  int by = 0;
  int wall_row = -1;
  int wall_col = -1;
  logic [23:0] bg_base = 24'h000000;

  sprite_overlay_engine #(.NUM_SPRITES(N)) dut (
    .iVGA_CLK   (clk),
    .reset      (reset),
    .iBLANK_n   (blank_n),
    .iVS        (vs),
    .iBG_BGR    (bg),
    .iWALL_COLOR(wall_color),
    .iSPR_EN    (spr_en),
    .iSPR_X     (spr_x),
    .iSPR_Y     (spr_y),
    .iSPR_COLOR (spr_color),
    .oBGR       (bgr),
    .oBLANK_n   (blank_out),
    .oVS        (vs_out),
    .oCOLL_UP   (coll_up),
    .oCOLL_DOWN (coll_down),
    .oCOLL_LEFT (coll_left),
    .oCOLL_RIGHT(coll_right),
    .oCOLL_VALID(coll_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] bg_of(input int px, input int py);
    if ((wall_row >= 0 && py == wall_row) || (wall_col >= 0 && px == wall_col)) return WALL;
    return bg_base;
  endfunction

  // One active pixel at the current raster position; blank stays high afterwards
  task automatic drive_px();
    blank_n = 1'b1;
    bg      = bg_of(bx, by);
    @(posedge clk); #1;
    if (bx == 639) begin
      bx = 0;
      if (by != 479) by++;
    end else begin
      bx++;
    end
  endtask

  task automatic run_to(input int tx, input int ty);
    int guard = 0;
    while (!(bx == tx && by == ty)) begin
      drive_px();
      guard++;
      if (guard > 40000) begin
        check("run_to_bound", 32'(guard), 32'd0);
        return;
      end
    end
  endtask

  // Drive the pixel at the current position, idle one cycle, then read its output
  task automatic probe(input string tag, input logic [23:0] exp);
    drive_px();
    blank_n = 1'b0;
    @(posedge clk); #1;
    check(tag, 32'(bgr), 32'(exp));
  endtask

  task automatic vsync(input string tag, input logic exp_valid);
    blank_n = 1'b0;
    vs      = 1'b1;
    @(posedge clk); #1;
    vs = 1'b0;
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(coll_valid), 32'(exp_valid));
    vs = 1'b1;
    @(posedge clk); #1;
    check({tag, "_ovs"}, 32'(vs_out), 32'd0);
    bx = 0;
    by = 0;
  endtask

  initial begin
    reset      = 1'b1;
    blank_n    = 1'b0;
    vs         = 1'b1;
    bg         = '0;
    wall_color = WALL;
    spr_en     = '0;
    spr_x      = '0;
    spr_y      = '0;
    spr_color  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bgr", 32'(bgr), 32'd0);
    check("rst_valid", 32'(coll_valid), 32'd0);
    check("rst_up", 32'(coll_up), 32'd0);
    check("rst_blank", 32'(blank_out), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Two empty frames on a black background
    vsync("b1", 1'b0);
    probe("empty_px_a", 24'h000000);
    check("blank_delay", 32'(blank_out), 32'd1);
    run_to(300, 1);
    probe("empty_px_b", 24'h000000);
    vsync("b2", 1'b1);
    check("b2_up", 32'(coll_up), 32'd0);
    check("b2_right", 32'(coll_right), 32'd0);

    // Overlapping sprites 0 and 1
    bg_base = 24'h0000AA;
    spr_en  = 4'b0011;
    spr_x[9:0]   = 10'd100;
    spr_x[19:10] = 10'd110;
    spr_y        = '0;
    spr_color[23:0]  = 24'hFF0000;
    spr_color[47:24] = 24'h00FF00;
    vsync("b3", 1'b1);
    run_to(115, 0);
    probe("top_row_bg", 24'h0000AA);
    run_to(115, 10);
    probe("overlap_prio", 24'hFF0000);
    @(posedge clk); #1;
    check("blank_zero", 32'(bgr), 32'd0);
    run_to(124, 10);
    probe("spr1_only", 24'h00FF00);
    run_to(130, 10);
    probe("spr1_inner", 24'h00FF00);
    run_to(134, 10);
    probe("spr1_right_edge", 24'h0000AA);
    run_to(100, 11);
    probe("spr0_left_edge", 24'h0000AA);
    probe("spr0_first_col", 24'hFF0000);

    // Mid-frame position change must wait for the next frame
    spr_x[9:0] = 10'd200;
    run_to(101, 12);
    probe("midframe_old", 24'hFF0000);
    run_to(201, 12);
    probe("midframe_new_absent", 24'h0000AA);
    vsync("b4", 1'b1);
    check("b4_up", 32'(coll_up), 32'd0);
    run_to(101, 5);
    probe("newframe_old_gone", 24'h0000AA);
    run_to(201, 5);
    probe("newframe_new", 24'hFF0000);

    // Wall on row 0 touches the top of both sprites
    spr_x[9:0] = 10'd100;
    vsync("b5", 1'b1);
    check("b5_up", 32'(coll_up), 32'd0);
    wall_row = 0;
    run_to(0, 2);
    spr_en = 4'b0001;
    vsync("b6", 1'b1);
    check("row_up", 32'(coll_up), 32'b0011);
    check("row_down", 32'(coll_down), 32'd0);
    check("row_left", 32'(coll_left), 32'd0);
    check("row_right", 32'(coll_right), 32'd0);

    // Wall on column 124 touches the right side of sprite 0
    wall_row = -1;
    wall_col = 124;
    run_to(0, 4);
    spr_x[9:0] = 10'd630;
    vsync("b7", 1'b1);
    check("col_right", 32'(coll_right), 32'b0001);
    check("col_up", 32'(coll_up), 32'd0);
    check("col_left", 32'(coll_left), 32'd0);

    // Sprite at the right edge clips instead of wrapping
    wall_col = -1;
    wall_row = 0;
    run_to(630, 5);
    probe("clip_x630", 24'h0000AA);
    probe("clip_x631", 24'hFF0000);
    run_to(639, 5);
    probe("clip_x639", 24'hFF0000);
    probe("nowrap_x0", 24'h0000AA);
    run_to(13, 6);
    probe("nowrap_x13", 24'h0000AA);
    check("hold_right", 32'(coll_right), 32'b0001);
    check("hold_valid", 32'(coll_valid), 32'd0);
    spr_x[9:0] = 10'd100;
    vsync("b8", 1'b1);
    check("edge_up", 32'(coll_up), 32'b0001);
    check("edge_right", 32'(coll_right), 32'd0);

    // Reset mid-frame with wall contact already accumulated
    run_to(0, 3);
    check("pre_reset_up", 32'(coll_up), 32'b0001);
    reset = 1'b1;
    #1;
    check("async_rst_up", 32'(coll_up), 32'd0);
    check("async_rst_bgr", 32'(bgr), 32'd0);
    @(posedge clk); #1;
    reset   = 1'b0;
    blank_n = 1'b0;
    bx = 0;
    by = 0;
    vsync("b9", 1'b0);
    run_to(0, 2);
    vsync("b10", 1'b1);
    check("post_rst_up", 32'(coll_up), 32'b0001);
    check("post_rst_right", 32'(coll_right), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
